// File: rtl/dpm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dpm_pkg
//  Purpose  : Shared sizing constants and word/address types for the
//             dual-port unified instruction/data memory.
//  Contents : DPM_DATA_WIDTH, DPM_ADDR_WIDTH, DPM_DEPTH, word_t, addr_t
//  Revision : 1.0  initial release
// ============================================================================
package dpm_pkg;

    localparam int DPM_DATA_WIDTH = 16;
    localparam int DPM_ADDR_WIDTH = 10;
    localparam int DPM_DEPTH      = 1 << DPM_ADDR_WIDTH;

    typedef logic [DPM_DATA_WIDTH-1:0] word_t;
    typedef logic [DPM_ADDR_WIDTH-1:0] addr_t;

endpackage : dpm_pkg
`default_nettype wire

// File: rtl/dual_port_memory.sv
`default_nettype none
// ============================================================================
//  Module   : dual_port_memory
//  Purpose  : True dual-port synchronous RAM (default 1024 x 16) shared by
//             the datapath (port A) and the fetch/IO side (port B).
//             Block-RAM inference form: one storage array, registered reads.
//  Ports    : clk              single rising-edge clock
//             reset            synchronous active-high; clears q_a/q_b only
//             data_a/addr_a/we_a  port A write data, address, write enable
//             q_a              port A registered read data (1-cycle latency)
//             data_b/addr_b/we_b  port B write data, address, write enable
//             q_b              port B registered read data (1-cycle latency)
//  Macros   : DPM_INIT_FILE_EN - when defined, the array powers up with
//             every word zero.
//             When undefined, contents are undefined until written.
//  Revision : 1.0  initial release
// ============================================================================
module dual_port_memory
    import dpm_pkg::*;
#(
    parameter int DATA_WIDTH = DPM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DPM_ADDR_WIDTH
`ifdef DPM_INIT_FILE_EN
    ,
    parameter     INIT_FILE  = "mem_init.hex"
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Shared storage; the address space covers exactly DEPTH words so every
    // address bit is decoded and no wrap handling exists.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] q_a_d;
    logic [DATA_WIDTH-1:0] q_a_q;
    logic [DATA_WIDTH-1:0] q_b_d;
    logic [DATA_WIDTH-1:0] q_b_q;

`ifdef DPM_INIT_FILE_EN
    // Program image area starts out zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = '0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Storage update. Both ports are handled in one process so the array
    // has a single driver. Port B's assignment is issued last, so when both
    // ports write the same word in one cycle port B's data is what remains.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_q[addr_a] <= data_a;
        end
        if (we_b) begin
            mem_q[addr_b] <= data_b;
        end
    end

    // ------------------------------------------------------------------
    // Read data selection.
    // A port that writes this cycle returns its own write data (write-first).
    // Otherwise it returns the array contents sampled before this edge, so a
    // write from the other port to the same word is not visible until the
    // following cycle (read-old across ports).
    // ------------------------------------------------------------------
    always_comb begin
        q_a_d = mem_q[addr_a];
        if (we_a) begin
            q_a_d = data_a;
        end
    end

    always_comb begin
        q_b_d = mem_q[addr_b];
        if (we_b) begin
            q_b_d = data_b;
        end
    end

    // Output registers. Reset clears only these; the array keeps its contents
    // and writes keep happening while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;

endmodule : dual_port_memory
`default_nettype wire

// File: tb/tb_dual_port_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dual_port_memory
//  Purpose  : Self-checking bench for dual_port_memory. Directed scenarios
//             followed by random traffic, all checked against an array-based
//             reference memory with per-word "written" flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dual_port_memory;
    import dpm_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    word_t data_a, data_b;
    addr_t addr_a, addr_b;
    logic  we_a, we_b;
    word_t q_a, q_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference memory: contents plus a flag telling whether a word has a
    // defined value yet (unwritten words power up undefined).
    word_t ref_mem [DPM_DEPTH];
    bit    ref_vld [DPM_DEPTH];

    dual_port_memory dut (
        .clk    (clk),
        .reset  (reset),
        .data_a (data_a),
        .addr_a (addr_a),
        .we_a   (we_a),
        .q_a    (q_a),
        .data_b (data_b),
        .addr_b (addr_b),
        .we_b   (we_b),
        .q_b    (q_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, check both read ports
    // against the reference, then commit the writes into the reference.
    task automatic step(input string tag, input logic rst,
                        input logic wa, input addr_t aa, input word_t da,
                        input logic wb, input addr_t ab, input word_t db);
        word_t ea, eb;
        bit    ka, kb;
        reset  = rst;
        we_a   = wa;  addr_a = aa;  data_a = da;
        we_b   = wb;  addr_b = ab;  data_b = db;
        @(posedge clk);
        #1;
        if (rst)     begin ea = '0;          ka = 1'b1;        end
        else if (wa) begin ea = da;          ka = 1'b1;        end
        else         begin ea = ref_mem[aa]; ka = ref_vld[aa]; end
        if (rst)     begin eb = '0;          kb = 1'b1;        end
        else if (wb) begin eb = db;          kb = 1'b1;        end
        else         begin eb = ref_mem[ab]; kb = ref_vld[ab]; end
        if (ka) check({tag, "_qa"}, q_a, ea);
        if (kb) check({tag, "_qb"}, q_b, eb);
        if (wa) begin ref_mem[aa] = da; ref_vld[aa] = 1'b1; end
        if (wb) begin ref_mem[ab] = db; ref_vld[ab] = 1'b1; end
    endtask

    initial begin
        addr_t ra, rb;
        word_t rda, rdb;
        logic  rwa, rwb, rrst;

        for (int i = 0; i < DPM_DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        reset = 1'b1; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

        // 1. Reset clears q; memory survives; writes still land during reset.
        step("rst0",   1'b1, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd0,   16'h0000);
        check("rst0_qa_zero", q_a, 16'h0000);
        check("rst0_qb_zero", q_b, 16'h0000);
        step("pre",    1'b0, 1'b1, 10'd100, 16'h1234, 1'b1, 10'd101, 16'h4321);
        step("rstw",   1'b1, 1'b1, 10'd200, 16'hBEEF, 1'b0, 10'd100, 16'h0000);
        check("rstw_qa_zero", q_a, 16'h0000);
        step("rdback", 1'b0, 1'b0, 10'd100, 16'h0000, 1'b0, 10'd200, 16'h0000);
        check("rdback_qa", q_a, 16'h1234);
        check("rdback_qb", q_b, 16'hBEEF);
        step("rdback2",1'b0, 1'b0, 10'd101, 16'h0000, 1'b0, 10'd100, 16'h0000);

        // 2. Same-port write-first, then cross-port read.
        step("t2w",    1'b0, 1'b1, 10'd1,   16'h0001, 1'b0, 10'd0,   16'h0000);
        check("t2_wf_qa", q_a, 16'h0001);
        step("t2r",    1'b0, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd1,   16'h0000);
        check("t2_qb", q_b, 16'h0001);

        // 3. Port B writes, port A reads back.
        step("t3w",    1'b0, 1'b0, 10'd0,   16'h0000, 1'b1, 10'd4,   16'h0002);
        step("t3r",    1'b0, 1'b0, 10'd4,   16'h0000, 1'b0, 10'd0,   16'h0000);
        check("t3_qa", q_a, 16'h0002);

        // 4. Cross-port read-during-write returns old data.
        step("t4pre",  1'b0, 1'b1, 10'd8,   16'h1111, 1'b0, 10'd0,   16'h0000);
        step("t4col",  1'b0, 1'b1, 10'd8,   16'hAAAA, 1'b0, 10'd8,   16'h0000);
        check("t4_old_qb", q_b, 16'h1111);
        step("t4nxt",  1'b0, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd8,   16'h0000);
        check("t4_new_qb", q_b, 16'hAAAA);

        // 5. Both ports write one word: B wins in memory, each q shows own data.
        step("t5w",    1'b0, 1'b1, 10'd16,  16'h00A0, 1'b1, 10'd16,  16'h00B0);
        check("t5_wf_qa", q_a, 16'h00A0);
        check("t5_wf_qb", q_b, 16'h00B0);
        step("t5r",    1'b0, 1'b0, 10'd16,  16'h0000, 1'b0, 10'd16,  16'h0000);
        check("t5_qa", q_a, 16'h00B0);
        check("t5_qb", q_b, 16'h00B0);

        // 6. Address extremes, no aliasing.
        step("t6w",    1'b0, 1'b1, 10'd1023, 16'hFFFF, 1'b1, 10'd0,   16'h5A5A);
        step("t6r1",   1'b0, 1'b0, 10'd1023, 16'h0000, 1'b0, 10'd0,   16'h0000);
        check("t6_qa_top", q_a, 16'hFFFF);
        check("t6_qb_bot", q_b, 16'h5A5A);
        step("t6r2",   1'b0, 1'b0, 10'd0,    16'h0000, 1'b0, 10'd1023, 16'h0000);
        check("t6_qa_bot", q_a, 16'h5A5A);
        check("t6_qb_top", q_b, 16'hFFFF);

        // 7. Random traffic. Addresses are mostly drawn from a small window so
        //    collisions and same-word read/write pairs happen often.
        for (int n = 0; n < 600; n++) begin
            ra   = ($urandom_range(0, 3) == 0) ? addr_t'($urandom) : addr_t'($urandom_range(0, 15));
            rb   = ($urandom_range(0, 3) == 0) ? addr_t'($urandom) : addr_t'($urandom_range(0, 15));
            rda  = word_t'($urandom);
            rdb  = word_t'($urandom);
            rwa  = ($urandom_range(0, 2) == 0);
            rwb  = ($urandom_range(0, 2) == 0);
            rrst = ($urandom_range(0, 19) == 0);
            step("rnd", rrst, rwa, ra, rda, rwb, rb, rdb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dual_port_memory
`default_nettype wire
